rj45_led_receiver: RTL and testbench

Serial-LED-bus receiver: the far end of the RJ45 indicator shift-register link. It oversamples the `sck`/`sin`/`lat`/`blk` lines with the system clock and deserializes the 16-bit padded frame. On each latch it validates the frame and presents the eight LED values in parallel. It sits on the DAQ loopback/test path and on remote boards that emulate the LED driver, so it also reports frame integrity and a frame count.

---
 rtl/rj45_led_receiver.sv | 147 ++++++++++++++
 tb/tb_rj45_led_receiver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rj45_led_receiver.sv
// Receiver end of the RJ45 serial LED link: oversamples sck/sin/lat/blk, deserializes the
// padded 16-bit frame and, on each latch, validates it and presents eight LED values.
module rj45_led_receiver #(
    parameter int unsigned MIN_BITS = 16
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        rj45_led_sck,
    input  logic        rj45_led_sin,
    input  logic        rj45_led_lat,
    input  logic        rj45_led_blk,
    output logic [7:0]  led_vals,
    output logic [7:0]  led_out,
    output logic        led_valid,
    output logic        frame_error,
    output logic [1:0]  error_code,
    output logic [15:0] frame_count
);

    // Pin bundle order: {blk, lat, sin, sck}
    logic [3:0]  pins;
    logic [3:0]  meta_q;
    logic [3:0]  sync_q;
    logic [3:0]  hist_q;
    logic [3:0]  rise;

    logic        sck_rise;
    logic        lat_rise;
    logic        sin_sync;
    logic        blk_sync;

    logic [15:0] shreg_q;
    logic [15:0] shreg_d;
    logic [4:0]  bit_cnt_q;
    logic [4:0]  bit_cnt_d;
    logic [4:0]  bit_cnt_upd;

    logic [7:0]  cand_vals;
    logic [7:0]  pad_bits;
    logic        pad_err;
    logic        short_err;

    logic [7:0]  led_vals_q;
    logic [7:0]  led_vals_d;
    logic [7:0]  led_out_q;
    logic [7:0]  led_out_d;
    logic        led_valid_q;
    logic        led_valid_d;
    logic        frame_error_q;
    logic        frame_error_d;
    logic [1:0]  error_code_q;
    logic [1:0]  error_code_d;
    logic [15:0] frame_count_q;
    logic [15:0] frame_count_d;

    assign pins     = {rj45_led_blk, rj45_led_lat, rj45_led_sin, rj45_led_sck};
    assign rise     = sync_q & ~hist_q;
    assign sck_rise = rise[0];
    assign lat_rise = rise[2];
    assign sin_sync = sync_q[1];
    assign blk_sync = sync_q[3];

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            meta_q <= pins;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    // The latch judges the post-shift values so a coincident sck edge lands in the frame.
    always_comb begin
        shreg_d     = shreg_q;
        bit_cnt_upd = bit_cnt_q;
        if (sck_rise) begin
            shreg_d = {shreg_q[14:0], sin_sync};
            if (bit_cnt_q != 5'd31) begin
                bit_cnt_upd = bit_cnt_q + 5'd1;
            end
        end

        cand_vals = '0;
        pad_bits  = '0;
        for (int i = 0; i < 8; i++) begin
            cand_vals[i] = shreg_d[14-2*i];
            pad_bits[i]  = shreg_d[15-2*i];
        end
        pad_err   = |pad_bits;
        short_err = 32'(bit_cnt_upd) < MIN_BITS;

        bit_cnt_d     = bit_cnt_upd;
        led_vals_d    = led_vals_q;
        led_valid_d   = 1'b0;
        frame_error_d = 1'b0;
        error_code_d  = error_code_q;
        frame_count_d = frame_count_q;

        if (lat_rise) begin
            bit_cnt_d = '0;
            if (!pad_err && !short_err) begin
                led_vals_d    = cand_vals;
                led_valid_d   = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
                error_code_d  = 2'b00;
            end else begin
                frame_error_d = 1'b1;
                error_code_d  = {short_err, pad_err};
            end
        end

        led_out_d = blk_sync ? 8'h00 : led_vals_q;
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            led_vals_q    <= '0;
            led_out_q     <= '0;
            led_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
            error_code_q  <= '0;
            frame_count_q <= '0;
        end else begin
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            led_vals_q    <= led_vals_d;
            led_out_q     <= led_out_d;
            led_valid_q   <= led_valid_d;
            frame_error_q <= frame_error_d;
            error_code_q  <= error_code_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign led_vals    = led_vals_q;
    assign led_out     = led_out_q;
    assign led_valid   = led_valid_q;
    assign frame_error = frame_error_q;
    assign error_code  = error_code_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_rj45_led_receiver.sv
// Directed bench for rj45_led_receiver: a bit-level model of the remote shift register
// predicts each latch result into a scoreboard queue, popped when the DUT pulses.
module tb_rj45_led_receiver;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sck = 1'b0;
    logic        sin = 1'b0;
    logic        lat = 1'b0;
    logic        blk = 1'b0;
    logic [7:0]  led_vals;
    logic [7:0]  led_out;
    logic        led_valid;
    logic        frame_error;
    logic [1:0]  error_code;
    logic [15:0] frame_count;

    rj45_led_receiver #(.MIN_BITS(16)) dut (
        .sys_clk      (sys_clk),
        .reset_n      (reset_n),
        .rj45_led_sck (sck),
        .rj45_led_sin (sin),
        .rj45_led_lat (lat),
        .rj45_led_blk (blk),
        .led_vals     (led_vals),
        .led_out      (led_out),
        .led_valid    (led_valid),
        .frame_error  (frame_error),
        .error_code   (error_code),
        .frame_count  (frame_count)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic        acc;
        logic [7:0]  vals;
        logic [1:0]  code;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] m_shreg = '0;
    logic [4:0]  m_cnt = '0;
    logic [7:0]  m_vals = '0;
    logic [15:0] m_count = '0;
    logic        prev_pulse = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses must be exclusive and never back-to-back.
    always @(negedge sys_clk) begin
        if (reset_n && (led_valid || frame_error)) begin
            tests++;
            assert (!(led_valid && frame_error) && !prev_pulse) else begin
                fails++;
                $error("FAIL pulse_shape: valid=%0b error=%0b prev=%0b required single exclusive",
                       led_valid, frame_error, prev_pulse);
            end
        end
        prev_pulse = reset_n && (led_valid || frame_error);
    end

    function automatic logic [15:0] enc(input logic [7:0] v);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[14-2*i] = v[i];
        return w;
    endfunction

    task automatic push_expect();
        logic [7:0] v;
        logic       pad;
        logic       short_f;
        exp_t       e;
        pad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v[i] = m_shreg[14-2*i];
            pad  = pad | m_shreg[15-2*i];
        end
        short_f = m_cnt < 5'd16;
        if (!pad && !short_f) begin
            m_vals  = v;
            m_count = m_count + 16'd1;
            e = '{acc: 1'b1, vals: m_vals, code: 2'b00, cnt: m_count};
        end else begin
            e = '{acc: 1'b0, vals: m_vals, code: {short_f, pad}, cnt: m_count};
        end
        sb.push_back(e);
        m_cnt = '0;
    endtask

    task automatic wait_result();
        logic seen;
        exp_t e;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge sys_clk);
            if (led_valid || frame_error) begin
                seen = 1'b1;
                e = sb.pop_front();
                check("accept", led_valid, e.acc);
                check("reject", frame_error, !e.acc);
                check("led_vals", led_vals, e.vals);
                check("error_code", error_code, e.code);
                check("frame_count", frame_count, e.cnt);
                @(negedge sys_clk);
                check("led_out", led_out, e.vals);
            end
        end
        check("result_seen", seen, 1);
    endtask

    task automatic shift_bit(input logic b, input logic with_lat);
        sin = b;
        sck = 1'b0;
        repeat (3) @(negedge sys_clk);
        m_shreg = {m_shreg[14:0], b};
        if (m_cnt != 5'd31) m_cnt = m_cnt + 5'd1;
        if (with_lat) push_expect();
        sck = 1'b1;
        lat = with_lat;
        if (with_lat) begin
            wait_result();
            lat = 1'b0;
        end
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) shift_bit(w[i], 1'b0);
    endtask

    task automatic do_latch();
        push_expect();
        lat = 1'b1;
        wait_result();
        lat = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vals"}, led_vals, 0);
        check({tag, "_out"}, led_out, 0);
        check({tag, "_valid"}, led_valid, 0);
        check({tag, "_ferr"}, frame_error, 0);
        check({tag, "_code"}, error_code, 0);
        check({tag, "_count"}, frame_count, 0);
    endtask

    initial begin
        logic [15:0] w;
        repeat (3) @(negedge sys_clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        check_all_zero("post_reset");

        // Nominal frame
        send_word(16'h4411);
        do_latch();
        check("nominal_a5", led_vals, 8'hA5);

        // Pad violation keeps prior values
        send_word(16'hC000);
        do_latch();
        check("pad_code", error_code, 2'b01);
        check("pad_keep", led_vals, 8'hA5);

        // Short frame, then a long free-running burst
        repeat (10) shift_bit(1'b0, 1'b0);
        do_latch();
        check("short_code", error_code, 2'b10);
        for (int i = 0; i < 24; i++) shift_bit(1'($urandom_range(0, 1)), 1'b0);
        send_word(enc(8'h3C));
        do_latch();
        check("long_3c", led_vals, 8'h3C);

        // 16th sck rise coincident with lat rise
        w = enc(8'h81);
        for (int i = 15; i >= 1; i--) shift_bit(w[i], 1'b0);
        shift_bit(w[0], 1'b1);
        check("simul_81", led_vals, 8'h81);

        // Blank
        send_word(enc(8'hFF));
        do_latch();
        blk = 1'b1;
        repeat (2) @(negedge sys_clk);
        check("blk_2cyc", led_out, 8'hFF);
        @(negedge sys_clk);
        check("blk_3cyc", led_out, 8'h00);
        check("blk_vals", led_vals, 8'hFF);
        blk = 1'b0;
        repeat (4) @(negedge sys_clk);
        check("unblank", led_out, 8'hFF);

        // Reset mid-frame
        repeat (5) shift_bit(1'b1, 1'b0);
        reset_n = 1'b0;
        sck = 1'b0;
        #1;
        check_all_zero("mid_reset");
        m_shreg = '0;
        m_cnt   = '0;
        m_vals  = '0;
        m_count = '0;
        repeat (3) @(negedge sys_clk);
        reset_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        send_word(enc(8'h5A));
        do_latch();
        check("after_reset_5a", led_vals, 8'h5A);

        // Counter wrap
        @(negedge sys_clk);
        force dut.frame_count_q = 16'hFFFF;
        @(negedge sys_clk);
        release dut.frame_count_q;
        m_count = 16'hFFFF;
        @(negedge sys_clk);
        check("preload", frame_count, 16'hFFFF);
        send_word(enc(8'h12));
        do_latch();
        check("wrap", frame_count, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
